// File: rtl/tl_pkg.sv
// Shared TL transmit types: stream beat, flow-control credit set, FC classes
// and the credit arithmetic used by the TX arbiter.
package tl_pkg;

  localparam int TL_HDR_CW  = 8;
  localparam int TL_DATA_CW = 12;
  localparam int TL_NUM_SRC = 3;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
  } tl_stream_t;

  typedef struct packed {
    logic [TL_HDR_CW-1:0]  ph;
    logic [TL_DATA_CW-1:0] pd;
    logic [TL_HDR_CW-1:0]  nph;
    logic [TL_DATA_CW-1:0] npd;
    logic [TL_HDR_CW-1:0]  cplh;
    logic [TL_DATA_CW-1:0] cpld;
  } fc_limit_t;

  // Source index doubles as the FC class.
  typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} fc_class_e;

  typedef enum logic {ST_ARB, ST_XFER} tx_state_e;

  // Modulo-2^width credit check: the request fits if the remaining window
  // (limit - (consumed + req)) lands in the lower half of the ring.
  function automatic logic fc_credit_ok(input logic [31:0] limit,
                                        input logic [31:0] consumed,
                                        input logic [31:0] req,
                                        input int          width);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (32'd1 << width) - 32'd1;
    diff = (limit - (consumed + req)) & mask;
    return diff <= (32'd1 << (width - 1));
  endfunction

  // Data credits (16B units) carried by a TLP, from header DW0.
  // Length 0 encodes 1024 DW, i.e. 256 credits.
  function automatic logic [TL_DATA_CW-1:0] tlp_data_credits(input logic [31:0] hdr);
    logic [10:0] len;
    len = {1'b0, hdr[17:16], hdr[31:24]};
    if (!hdr[6]) return '0;
    if (len == 11'd0) return TL_DATA_CW'(256);
    len = len + 11'd3;
    return TL_DATA_CW'(len[10:2]);
  endfunction

endpackage

// File: rtl/tl_tx_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module tl_tx_rr_arb #(
  parameter int NUM_SRC = 3
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [NUM_SRC-1:0]         gnt
);

  localparam int PW = $clog2(NUM_SRC);

  // Scan from the pointer and keep the first hit only.
  always_comb begin
    int          tmp;
    logic [PW-1:0] idx;
    gnt = '0;
    tmp = 0;
    idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tmp = int'(ptr) + i;
      if (tmp >= NUM_SRC) tmp = tmp - NUM_SRC;
      idx = PW'(tmp);
      if (req[idx] && gnt == '0) gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/tl_tx_arbiter.sv
// Packet-atomic TL TX scheduler: round-robin among credit-eligible sources,
// whole packet SOP..EOP, one arbitration bubble between packets.
module tl_tx_arbiter #(
  parameter int HDR_CW  = tl_pkg::TL_HDR_CW,
  parameter int DATA_CW = tl_pkg::TL_DATA_CW,
  parameter int NUM_SRC = tl_pkg::TL_NUM_SRC
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  tl_pkg::tl_stream_t [NUM_SRC-1:0]     src_i,
  input  logic [NUM_SRC-1:0]                   src_valid_i,
  output logic [NUM_SRC-1:0]                   src_ready_o,
  output tl_pkg::tl_stream_t                   tl_tx_o,
  output logic                                 tl_tx_valid_o,
  input  logic                                 tl_tx_ready_i,
  input  logic                                 fc_init_done_i,
  input  tl_pkg::fc_limit_t                    fc_limit_i,
  output tl_pkg::fc_limit_t                    fc_consumed_o,
  output logic [NUM_SRC-1:0]                   grant_o,
  output logic                                 proto_err_o
);

  import tl_pkg::*;

  localparam int PW = $clog2(NUM_SRC);

  tx_state_e                        state;
  logic [NUM_SRC-1:0]               grant_q;
  logic [PW-1:0]                    gidx;
  logic [PW-1:0]                    rr_ptr;
  logic                             first_beat;
  fc_limit_t                        cons_q;
  logic                             perr_q;

  logic [NUM_SRC-1:0]               elig;
  logic [NUM_SRC-1:0]               pick;
  logic [PW-1:0]                    pidx;
  logic [NUM_SRC-1:0][DATA_CW-1:0]  dreq;
  logic                             hs;

  assign grant_o       = grant_q;
  assign fc_consumed_o = cons_q;
  assign proto_err_o   = perr_q;
  assign hs            = tl_tx_valid_o && tl_tx_ready_i;

  // Per-source credit requirement and eligibility from the presented SOP header.
  always_comb begin
    logic [31:0] hl, hc, dl, dc;
    hl = '0; hc = '0; dl = '0; dc = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      dreq[s] = DATA_CW'(tlp_data_credits(src_i[s].data[31:0]));
      case (s)
        0: begin
          hl = 32'(fc_limit_i.ph);   hc = 32'(cons_q.ph);
          dl = 32'(fc_limit_i.pd);   dc = 32'(cons_q.pd);
        end
        1: begin
          hl = 32'(fc_limit_i.nph);  hc = 32'(cons_q.nph);
          dl = 32'(fc_limit_i.npd);  dc = 32'(cons_q.npd);
        end
        default: begin
          hl = 32'(fc_limit_i.cplh); hc = 32'(cons_q.cplh);
          dl = 32'(fc_limit_i.cpld); dc = 32'(cons_q.cpld);
        end
      endcase
      elig[s] = src_valid_i[s] && src_i[s].sop && fc_init_done_i &&
                fc_credit_ok(hl, hc, 32'd1, HDR_CW) &&
                (dreq[s] == '0 || fc_credit_ok(dl, dc, 32'(dreq[s]), DATA_CW));
    end
  end

  tl_tx_rr_arb #(.NUM_SRC(NUM_SRC)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Encode the one-hot pick for muxing and counter selection.
  always_comb begin
    pidx = '0;
    for (int s = 0; s < NUM_SRC; s++)
      if (pick[s]) pidx = PW'(s);
  end

  // Pass-through of the granted source while a packet is in flight.
  always_comb begin
    tl_tx_o       = '0;
    tl_tx_valid_o = 1'b0;
    src_ready_o   = '0;
    if (state == ST_XFER) begin
      tl_tx_o           = src_i[gidx];
      tl_tx_valid_o     = src_valid_i[gidx];
      src_ready_o[gidx] = tl_tx_ready_i;
    end
  end

  // Arbitration FSM: grant, credit accounting, rr pointer, sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      grant_q    <= '0;
      gidx       <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
      cons_q     <= '0;
      perr_q     <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (|pick) begin
            grant_q    <= pick;
            gidx       <= pidx;
            rr_ptr     <= (pidx == PW'(NUM_SRC - 1)) ? '0 : pidx + 1'b1;
            first_beat <= 1'b1;
            state      <= ST_XFER;
            case (fc_class_e'(pidx))
              FC_P: begin
                cons_q.ph <= cons_q.ph + 1'b1;
                cons_q.pd <= cons_q.pd + dreq[pidx];
              end
              FC_NP: begin
                cons_q.nph <= cons_q.nph + 1'b1;
                cons_q.npd <= cons_q.npd + dreq[pidx];
              end
              default: begin
                cons_q.cplh <= cons_q.cplh + 1'b1;
                cons_q.cpld <= cons_q.cpld + dreq[pidx];
              end
            endcase
          end
        end
        default: begin
          if (hs) begin
            first_beat <= 1'b0;
            if (!first_beat && tl_tx_o.sop) perr_q <= 1'b1;
            if (tl_tx_o.eop) begin
              state   <= ST_ARB;
              grant_q <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Scoreboard bench for tl_tx_arbiter: per-source expected beat queues filled
// when packets are queued, drained as the DUT forwards beats.
module tb_tl_tx_arbiter;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tl_stream_t [2:0] src_i;
  logic [2:0]       src_valid_i;
  logic [2:0]       src_ready_o;
  tl_stream_t       tl_tx_o;
  logic             tl_tx_valid_o;
  logic             tl_tx_ready_i;
  logic             fc_init_done_i;
  fc_limit_t        fc_limit_i;
  fc_limit_t        fc_consumed_o;
  logic [2:0]       grant_o;
  logic             proto_err_o;

  tl_tx_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_i          (src_i),
    .src_valid_i    (src_valid_i),
    .src_ready_o    (src_ready_o),
    .tl_tx_o        (tl_tx_o),
    .tl_tx_valid_o  (tl_tx_valid_o),
    .tl_tx_ready_i  (tl_tx_ready_i),
    .fc_init_done_i (fc_init_done_i),
    .fc_limit_i     (fc_limit_i),
    .fc_consumed_o  (fc_consumed_o),
    .grant_o        (grant_o),
    .proto_err_o    (proto_err_o)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  tl_stream_t src_q[3][$];
  tl_stream_t exp_q[3][$];
  fc_limit_t  mdl;
  int         n_sop[3] = '{0, 0, 0};
  int         log_src[$];
  int         log_cyc[$];
  logic       rdy_toggle = 1'b0;
  logic       rdy_hold   = 1'b1;
  logic       in_pkt     = 1'b0;
  logic [2:0] pkt_gnt    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int dcred(input logic [127:0] d);
    int len;
    len = int'({d[17:16], d[31:24]});
    if (!d[6]) return 0;
    if (len == 0) return 256;
    return (len + 3) / 4;
  endfunction

  function automatic bit busy();
    for (int s = 0; s < 3; s++)
      if (src_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b1;
    return in_pkt;
  endfunction

  task automatic push_pkt(input int s, input int nb, input bit fmt1, input int len, input bit stray = 1'b0);
    for (int i = 0; i < nb; i++) begin
      tl_stream_t b;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.sop  = (i == 0) || (stray && i == 1);
      b.eop  = (i == nb - 1);
      if (i == 0) begin
        b.data[6]     = fmt1;
        b.data[31:24] = len[7:0];
        b.data[17:16] = len[9:8];
      end
      src_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_busy"}, 32'(busy()), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_ample();
    fc_limit_i.ph   = mdl.ph   + 8'd64;
    fc_limit_i.nph  = mdl.nph  + 8'd64;
    fc_limit_i.cplh = mdl.cplh + 8'd64;
    fc_limit_i.pd   = mdl.pd   + 12'd512;
    fc_limit_i.npd  = mdl.npd  + 12'd512;
    fc_limit_i.cpld = mdl.cpld + 12'd512;
  endtask

  // Source driver: present queue heads, retire on handshake, drive DLL ready.
  initial begin
    logic [2:0] hs;
    src_valid_i   = '0;
    src_i         = '0;
    tl_tx_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      hs = src_valid_i & src_ready_o;
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
        if (hs[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
        if (src_q[s].size() > 0) begin
          src_valid_i[s] = 1'b1;
          src_i[s]       = src_q[s][0];
        end else begin
          src_valid_i[s] = 1'b0;
          src_i[s]       = '0;
        end
      end
      tl_tx_ready_i = rdy_toggle ? ~tl_tx_ready_i : rdy_hold;
    end
  end

  // Output monitor: scoreboard compare, packet atomicity, credit model.
  initial begin
    int g;
    int dc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pkt = 1'b0;
      end else begin
        chk("src_ready", src_ready_o, grant_o & {3{tl_tx_ready_i}});
        if (tl_tx_valid_o && tl_tx_ready_i) begin
          g = 0;
          for (int s = 0; s < 3; s++) if (grant_o[s]) g = s;
          chk("grant_onehot", 32'($onehot(grant_o)), 1);
          if (in_pkt) begin
            chk("no_interleave", grant_o, pkt_gnt);
          end else begin
            chk("first_sop", tl_tx_o.sop, 1);
            pkt_gnt = grant_o;
            n_sop[g]++;
            log_src.push_back(g);
            log_cyc.push_back(cyc);
            dc = dcred(tl_tx_o.data);
            case (g)
              0: begin mdl.ph   = mdl.ph   + 8'd1; mdl.pd   = mdl.pd   + 12'(dc); end
              1: begin mdl.nph  = mdl.nph  + 8'd1; mdl.npd  = mdl.npd  + 12'(dc); end
              default: begin mdl.cplh = mdl.cplh + 8'd1; mdl.cpld = mdl.cpld + 12'(dc); end
            endcase
          end
          chk("beat_expected", 32'(exp_q[g].size() > 0), 1);
          if (exp_q[g].size() > 0) chk("beat", tl_tx_o, exp_q[g].pop_front());
          in_pkt = !tl_tx_o.eop;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int n;
    int base;
    rst_n          = 1'b0;
    fc_init_done_i = 1'b0;
    fc_limit_i     = '0;
    mdl            = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_grant", grant_o, 0);
    chk("rst_valid", tl_tx_valid_o, 0);
    chk("rst_ready", src_ready_o, 0);
    chk("rst_cons", fc_consumed_o, 0);
    chk("rst_perr", proto_err_o, 0);
    chk("rst_tx", tl_tx_o, 0);
    rst_n = 1'b1;

    // Test 1: single P MWr, 3 beats, len 8; blocked until FC init done
    fc_limit_i.ph = 8'd1;
    fc_limit_i.pd = 12'd10;
    push_pkt(0, 3, 1'b1, 8);
    repeat (5) @(negedge clk);
    chk("init_block", n_sop[0], 0);
    fc_init_done_i = 1'b1;
    t0 = cyc;
    drain("t1", 100);
    chk("t1_nsop", log_src.size(), 1);
    if (log_src.size() > 0) begin
      chk("t1_src", log_src[0], 0);
      chk("t1_latency", log_cyc[0] - t0, 1);
    end
    chk("t1_ph", fc_consumed_o.ph, 1);
    chk("t1_pd", fc_consumed_o.pd, 2);
    chk("t1_cons_mdl", fc_consumed_o, mdl);

    // Test 2: all three sources, single-beat packets, round robin with bubbles
    set_ample();
    log_src.delete();
    log_cyc.delete();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 3; s++) push_pkt(s, 1, s != 2, 1);
    drain("t2", 100);
    chk("t2_count", log_src.size(), 6);
    for (int k = 0; k < log_src.size(); k++) begin
      chk("t2_rr_order", log_src[k], (1 + k) % 3);
      if (k > 0) chk("t2_bubble", log_cyc[k] - log_cyc[k-1], 2);
    end
    chk("t2_cons_mdl", fc_consumed_o, mdl);

    // Test 3: CplD len 16 blocked at CPLD limit 3, granted at 4
    set_ample();
    fc_limit_i.cpld = 12'd3;
    base = n_sop[2];
    push_pkt(2, 2, 1'b1, 16);
    push_pkt(0, 2, 1'b1, 4);
    push_pkt(1, 1, 1'b0, 1);
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("t3_pnp_done", exp_q[0].size() + exp_q[1].size(), 0);
    chk("t3_cpl_blocked", n_sop[2] - base, 0);
    chk("t3_cpl_pending", exp_q[2].size(), 2);
    fc_limit_i.cpld = 12'd4;
    drain("t3", 100);
    chk("t3_cpld", fc_consumed_o.cpld, 4);
    chk("t3_cons_mdl", fc_consumed_o, mdl);

    // Test 4: DLL backpressure toggling during a 4-beat NP packet
    set_ample();
    rdy_toggle = 1'b1;
    push_pkt(1, 4, 1'b1, 12);
    push_pkt(0, 2, 1'b1, 3);
    drain("t4", 200);
    rdy_toggle = 1'b0;
    rdy_hold   = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_cons_mdl", fc_consumed_o, mdl);

    // Test 5: PH counter wrap at 255 -> 0, then blocked until limit 1
    set_ample();
    for (int i = 0; i < 300 && mdl.ph != 8'd255; i++) begin
      fc_limit_i.ph = mdl.ph + 8'd1;
      push_pkt(0, 1, 1'b0, 1);
      drain("t5_fill", 50);
    end
    chk("t5_at255", fc_consumed_o.ph, 255);
    fc_limit_i.ph = 8'd0;
    push_pkt(0, 1, 1'b0, 1);
    drain("t5_wrap", 50);
    chk("t5_ph_wrap", fc_consumed_o.ph, 0);
    push_pkt(0, 1, 1'b0, 1);
    repeat (10) @(negedge clk);
    chk("t5_blocked", exp_q[0].size(), 1);
    chk("t5_idle_grant", grant_o, 0);
    fc_limit_i.ph = 8'd1;
    drain("t5_unblock", 50);
    chk("t5_ph", fc_consumed_o.ph, 1);

    // Test 6: reset mid-packet, then a packet with a stray SOP on beat 2
    set_ample();
    rdy_hold = 1'b0;
    push_pkt(1, 4, 1'b1, 8);
    n = 0;
    while (grant_o == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_granted", grant_o, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", tl_tx_valid_o, 0);
    chk("t6_rst_ready", src_ready_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_cons", fc_consumed_o, 0);
    chk("t6_rst_tx", tl_tx_o, 0);
    for (int s = 0; s < 3; s++) begin
      src_q[s].delete();
      exp_q[s].delete();
    end
    mdl      = '0;
    rdy_hold = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_ample();
    @(negedge clk);
    chk("t6_perr_clear", proto_err_o, 0);
    push_pkt(0, 3, 1'b1, 8, 1'b1);
    drain("t6_stray", 100);
    chk("t6_perr", proto_err_o, 1);
    push_pkt(1, 2, 1'b1, 4);
    drain("t6_after", 100);
    chk("t6_perr_sticky", proto_err_o, 1);
    chk("t6_cons_mdl", fc_consumed_o, mdl);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_tx_arbiter.md
Name: tl_tx_arbiter

Overview:
- Packet-atomic scheduler sharing the single TL transmit stream to the DLL between three TLP sources:
  - source 0: posted (user MWr)
  - source 1: non-posted (MRd/CfgRd/CfgWr requests)
  - source 2: completion (completion generator Cpl/CplD)
- Grants a whole packet, SOP to EOP, round-robin among sources that are eligible for link flow-control credits.
- Tracks credits consumed per FC class. Sits between the TL TX sources and the DLL TX interface; mirrors the RX parser on the receive side.

Parameters:
- HDR_CW, 8, header credit counter width (PCIe modulo-256 arithmetic)
- DATA_CW, 12, data credit counter width (PCIe modulo-4096 arithmetic)
- NUM_SRC, 3, number of sources; fixed at 3, the index defines the FC class

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_i  in  NUM_SRC x tl_pkg::tl_stream_t  per-source stream {data[127:0], sop, eop}
- src_valid_i  in  NUM_SRC  per-source beat valid
- src_ready_o  out  NUM_SRC  per-source beat accept
- tl_tx_o  out  tl_pkg::tl_stream_t  stream to DLL
- tl_tx_valid_o  out  1  beat valid to DLL
- tl_tx_ready_i  in  1  DLL accepts beat
- fc_init_done_i  in  1  FC initialisation complete; no grants while low
- fc_limit_i  in  tl_pkg::fc_limit_t  credit limits {ph, pd, nph, npd, cplh, cpld}; hdr fields HDR_CW, data fields DATA_CW
- fc_consumed_o  out  tl_pkg::fc_limit_t  credits-consumed counters, same layout
- grant_o  out  NUM_SRC  one-hot current grant, 0 when idle
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n low):
  - state = ST_ARB
  - grant_o = 0, rr pointer = 0
  - fc_consumed_o = 0, proto_err_o = 0
  - src_ready_o = 0, tl_tx_valid_o = 0, tl_tx_o = '0
  - An in-flight packet is abandoned; the source must restart it at SOP.
- Credit requirement, computed from the header beat presented with sop:
  - len = {data[17:16], data[31:24]}; len==0 means 1024 DW.
  - has_data = data[6] (Fmt[1]).
  - hdr_req = 1.
  - data_req = has_data ? ceil(len/4) : 0, so len 1..4 → 1 and len 0 → 256.
  - Class is set by source index: 0 → P, 1 → NP, 2 → CPL.
- Eligibility of source s: src_valid_i[s] && src_i[s].sop && fc_init_done_i && hdr_ok && data_ok.
  - x_ok = ((limit − (consumed + req)) mod 2^W) <= 2^(W−1), with W = HDR_CW or DATA_CW as appropriate.
  - data_ok is forced true when data_req == 0.
- FSM:
  - ST_ARB:
    - All src_ready_o = 0, tl_tx_valid_o = 0.
    - If any source is eligible, pick the first eligible at or after the rr pointer (wrapping 2→0).
    - Register grant, add hdr_req/data_req to that class's consumed counters (wrap modulo), set rr = grant+1 mod 3, go to ST_XFER.
    - Grant takes effect the cycle after eligibility; the SOP beat is held by the source, not consumed, in ST_ARB.
  - ST_XFER:
    - Combinational pass-through: tl_tx_o = src_i[g], tl_tx_valid_o = src_valid_i[g], src_ready_o[g] = tl_tx_ready_i, others 0.
    - On a beat handshake with eop, go to ST_ARB and clear grant_o the next cycle.
    - A single-beat packet (sop & eop) completes in one ST_XFER cycle.
  - Arbitration bubble: exactly one idle cycle between packets (ST_ARB).
- Source with insufficient credits:
  - Skipped without blocking the others.
  - Re-evaluated every ST_ARB cycle as fc_limit_i advances.
- Protocol errors:
  - A sop on a handshaken beat in ST_XFER other than the first beat sets proto_err_o, sticky until reset.
  - The beat is still forwarded.
- fc_init_done_i falling mid-packet does not abort the current packet; it only blocks new grants.
- fc_limit_i changes are sampled combinationally in ST_ARB only.

Decomposition:
- Add to tl_pkg:
  - fc_limit_t struct
  - fc_class_e {FC_P, FC_NP, FC_CPL}
  - function fc_credit_ok(limit, consumed, req, width)
  - function tlp_data_credits(hdr)
- Sub-module tl_tx_rr_arb: NUM_SRC-wide round-robin picker (req vector, pointer → one-hot grant); purely combinational. The FSM, credit counters and mux live in tl_tx_arbiter.

Test Plan:
- Single source: P MWr, 3 beats, len=8, PD limit 10, PH 1 → granted one cycle after SOP, 3 beats forwarded, fc_consumed ph=1, pd=2.
- All three valid with single-beat packets, ample credits → grant order 0,1,2,0,… with one idle cycle between packets.
- CPL source: CplD len=16, CPLD limit 3, consumed 0 → never granted while P/NP proceed; raise limit to 4 → granted, cpld consumed=4.
- Backpressure: tl_tx_ready_i toggled 1/0 during a 4-beat NP packet → beats held stable, no interleaving, src_ready_o tracks ready.
- Wrap: PH consumed=255, limit=0 (mod 256) → one packet granted, consumed wraps to 0; next blocked until limit=1.
- Reset mid-packet and stray SOP: assert rst_n low in ST_XFER → all outputs 0 in the same cycle; after release, send a packet with sop on beat 2 → proto_err_o=1 and held.
